// File: rtl/dmem_responder.sv
// dmem_responder
//   Byte-addressed data memory answering the memory stage's external data
//   interface. Stores (SB/SH/SW) commit on the rising edge with byte lanes;
//   loads are combinational and extended according to funct3. Misaligned or
//   illegal stores are dropped and flagged through a sticky error. A store
//   counter is kept for debug.
//
//   Optional macro DMEM_MMIO_EN: the top word of the address space becomes a
//   32-bit output register (o_mmio_reg) instead of RAM.
//
// Ports
//   i_clk          clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_dmem_we      store request this cycle
//   i_dmem_addr    byte address
//   i_dmem_wdata   store data, relevant bytes in the low lanes
//   i_dmem_f3      funct3 of the load or store
//   o_dmem_rdata   load data, extended and right-aligned (combinational)
//   i_err_clr      clears the sticky error and its captured address
//   o_misalign_err sticky: a misaligned or illegal store was dropped
//   o_err_addr     address of the first dropped store since the last clear
//   o_store_cnt    count of committed stores (wraps)
//   o_mmio_reg     memory-mapped output register (DMEM_MMIO_EN only)
module dmem_responder #(
    parameter int P_DATA_WIDTH      = 32,
    parameter int P_DMEM_ADDR_WIDTH = 11,
    parameter int P_CNT_WIDTH       = 16
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_dmem_we,
    input  logic [P_DMEM_ADDR_WIDTH-1:0] i_dmem_addr,
    input  logic [P_DATA_WIDTH-1:0]      i_dmem_wdata,
    input  logic [2:0]                   i_dmem_f3,
    output logic [P_DATA_WIDTH-1:0]      o_dmem_rdata,
    input  logic                         i_err_clr,
    output logic                         o_misalign_err,
    output logic [P_DMEM_ADDR_WIDTH-1:0] o_err_addr,
    output logic [P_CNT_WIDTH-1:0]       o_store_cnt
`ifdef DMEM_MMIO_EN
    ,
    output logic [P_DATA_WIDTH-1:0]      o_mmio_reg
`endif
);

    localparam int LP_DEPTH = 2 ** (P_DMEM_ADDR_WIDTH - 2);

    logic [P_DATA_WIDTH-1:0]      mem [LP_DEPTH];
    logic [P_DMEM_ADDR_WIDTH-3:0] widx;
    logic [1:0]                   off;
    logic                         mmio_hit;
    logic [P_DATA_WIDTH-1:0]      rd_word;

    logic                         store_ok;
    logic [3:0]                   lane_en;
    logic [P_DATA_WIDTH-1:0]      lane_data;
    logic                         commit;
    logic                         bad_store;

    // Extracts the selected byte/halfword/word from a memory word and
    // extends it; misaligned or unsupported loads read as zero.
    function automatic logic [P_DATA_WIDTH-1:0] load_extend(
        input logic [P_DATA_WIDTH-1:0] word,
        input logic [1:0]              boff,
        input logic [2:0]              f3
    );
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] res;
        b   = signed'(word[{boff, 3'b000} +: 8]);
        h   = signed'(word[{boff[1], 4'b0000} +: 16]);
        res = '0;
        case (f3)
            3'b000:  res = 32'(b);
            3'b100:  res = signed'({24'h0, b});
            3'b001:  if (!boff[0]) res = 32'(h);
            3'b101:  if (!boff[0]) res = signed'({16'h0, h});
            3'b010:  if (boff == 2'b00) res = signed'(word);
            default: res = '0;
        endcase
        return unsigned'(res);
    endfunction

    assign widx = i_dmem_addr[P_DMEM_ADDR_WIDTH-1:2];
    assign off  = i_dmem_addr[1:0];

`ifdef DMEM_MMIO_EN
    assign mmio_hit = &widx;
    assign rd_word  = mmio_hit ? o_mmio_reg : mem[widx];
`else
    assign mmio_hit = 1'b0;
    assign rd_word  = mem[widx];
`endif

    // Reads see the pre-edge contents, so a same-cycle write to the same
    // word is only visible one cycle later.
    assign o_dmem_rdata = load_extend(rd_word, off, i_dmem_f3);

    // Store decode: lane enables, replicated data and legality.
    always_comb begin
        store_ok  = 1'b0;
        lane_en   = 4'b0000;
        lane_data = i_dmem_wdata;
        case (i_dmem_f3)
            3'b000: begin
                store_ok  = 1'b1;
                lane_en   = 4'b0001 << off;
                lane_data = {4{i_dmem_wdata[7:0]}};
            end
            3'b001: begin
                store_ok  = ~off[0];
                lane_en   = off[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{i_dmem_wdata[15:0]}};
            end
            3'b010: begin
                store_ok  = (off == 2'b00);
                lane_en   = 4'b1111;
                lane_data = i_dmem_wdata;
            end
            default: begin
                store_ok  = 1'b0;
                lane_en   = 4'b0000;
                lane_data = i_dmem_wdata;
            end
        endcase
    end

    assign commit    = i_dmem_we & store_ok;
    assign bad_store = i_dmem_we & ~store_ok;

    // RAM array: no reset, byte-lane writes.
    always_ff @(posedge i_clk) begin
        if (commit && !mmio_hit) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) mem[widx][8*i +: 8] <= lane_data[8*i +: 8];
            end
        end
    end

`ifdef DMEM_MMIO_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_mmio_reg <= '0;
        end else if (commit && mmio_hit) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) o_mmio_reg[8*i +: 8] <= lane_data[8*i +: 8];
            end
        end
    end
`endif

    // Sticky error and store counter. A bad store on the same edge as a
    // clear wins and re-captures its own address.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_misalign_err <= 1'b0;
            o_err_addr     <= '0;
            o_store_cnt    <= '0;
        end else begin
            if (bad_store) begin
                o_misalign_err <= 1'b1;
                if (!o_misalign_err || i_err_clr) o_err_addr <= i_dmem_addr;
            end else if (i_err_clr) begin
                o_misalign_err <= 1'b0;
                o_err_addr     <= '0;
            end
            if (commit) o_store_cnt <= o_store_cnt + P_CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [10:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [31:0] rdata;
    logic        clr;
    logic        err;
    logic [10:0] eaddr;
    logic [15:0] cnt;
`ifdef DMEM_MMIO_EN
    logic [31:0] mmio;
`endif

    dmem_responder dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_dmem_we      (we),
        .i_dmem_addr    (addr),
        .i_dmem_wdata   (wdata),
        .i_dmem_f3      (f3),
        .o_dmem_rdata   (rdata),
        .i_err_clr      (clr),
        .o_misalign_err (err),
        .o_err_addr     (eaddr),
        .o_store_cnt    (cnt)
`ifdef DMEM_MMIO_EN
        ,
        .o_mmio_reg     (mmio)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: flat byte array plus the architectural registers.
    logic [7:0]  bmem [2048];
    logic        err_m;
    logic [10:0] eaddr_m;
    logic [15:0] cnt_m;
    logic [31:0] mmio_m;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic bit in_mmio(input int a);
`ifdef DMEM_MMIO_EN
        return a >= 2044;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [7:0] get_byte(input int a);
        if (in_mmio(a)) return mmio_m[8*(a-2044) +: 8];
        return bmem[a];
    endfunction

    function automatic logic [31:0] mload(input logic [10:0] a, input logic [2:0] fn);
        int sz;
        logic [31:0] v;
        logic [31:0] mask;
        sz = 1 << fn[1:0];
        v  = '0;
        if (fn == 3'd3 || fn >= 3'd6) return '0;
        if ((int'(a) % sz) != 0) return '0;
        for (int k = 0; k < sz; k++) v = v | (32'(get_byte(int'(a) + k)) << (8*k));
        if (!fn[2] && sz < 4) begin
            mask = (32'h1 << (8*sz)) - 32'h1;
            if (v[8*sz-1]) v = v | ~mask;
        end
        return v;
    endfunction

    task automatic mstore(input bit w, input logic [10:0] a, input logic [2:0] fn,
                          input logic [31:0] d, input bit c);
        int  sz;
        bit  legal;
        bit  bad;
        bad = 1'b0;
        if (w) begin
            sz    = 1 << fn[1:0];
            legal = (fn <= 3'd2) && ((int'(a) % sz) == 0);
            if (legal) begin
                for (int k = 0; k < sz; k++) begin
                    if (in_mmio(int'(a) + k)) mmio_m[8*(int'(a)+k-2044) +: 8] = d[8*k +: 8];
                    else bmem[int'(a) + k] = d[8*k +: 8];
                end
                cnt_m = cnt_m + 16'd1;
            end else begin
                bad = 1'b1;
                if (!err_m || c) eaddr_m = a;
                err_m = 1'b1;
            end
        end
        if (c && !bad) begin
            err_m   = 1'b0;
            eaddr_m = '0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_regs();
        chk("err", 32'(err), 32'(err_m));
        chk("err_addr", 32'(eaddr), 32'(eaddr_m));
        chk("store_cnt", 32'(cnt), 32'(cnt_m));
`ifdef DMEM_MMIO_EN
        chk("mmio_reg", mmio, mmio_m);
`endif
    endtask

    // One bus cycle: drive at negedge, check load data before the edge,
    // advance the model at the edge, check registers just after.
    task automatic step(input bit w, input logic [10:0] a, input logic [2:0] fn,
                        input logic [31:0] d, input bit c, output logic [31:0] rd);
        logic [31:0] exp_rd;
        @(negedge clk);
        we = w; addr = a; f3 = fn; wdata = d; clr = c;
        #1;
        exp_rd = mload(a, fn);
        rd = rdata;
        chk("rdata", rd, exp_rd);
        @(posedge clk);
        mstore(w, a, fn, d, c);
        #1;
        check_regs();
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        we = 1'b0; clr = 1'b0;
        rst_n = 1'b0;
        #1;
        err_m = 1'b0; eaddr_m = '0; cnt_m = '0; mmio_m = '0;
        check_regs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] rd;
        logic [15:0] cnt_save;
        we = 1'b0; addr = '0; wdata = '0; f3 = '0; clr = 1'b0;
        err_m = 1'b0; eaddr_m = '0; cnt_m = '0; mmio_m = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_regs();
        @(negedge clk);
        rst_n = 1'b1;

        // Fill the whole memory so the model is fully defined.
        for (int w = 0; w < 512; w++) begin
            @(negedge clk);
            we = 1'b1; addr = 11'(w << 2); f3 = 3'b010; wdata = $urandom; clr = 1'b0;
            @(posedge clk);
            mstore(1'b1, addr, 3'b010, wdata, 1'b0);
        end
        pulse_reset();

        // Word store then load.
        step(1, 11'h010, 3'b010, 32'hDEADBEEF, 0, rd);
        step(0, 11'h010, 3'b010, 32'h0, 0, rd);
        chk("sw_lw", rd, 32'hDEADBEEF);
        chk("sw_cnt", 32'(cnt), 32'd1);

        // Byte store into a zero word, signed/unsigned byte loads.
        step(1, 11'h010, 3'b010, 32'h0, 0, rd);
        step(1, 11'h013, 3'b000, 32'h12345680, 0, rd);
        step(0, 11'h013, 3'b000, 32'h0, 0, rd);
        chk("lb", rd, 32'hFFFFFF80);
        step(0, 11'h013, 3'b100, 32'h0, 0, rd);
        chk("lbu", rd, 32'h00000080);
        step(0, 11'h010, 3'b010, 32'h0, 0, rd);
        chk("sb_word", rd, 32'h80000000);

        // Halfword store to the upper half; low half preserved.
        step(1, 11'h020, 3'b010, 32'h13572468, 0, rd);
        step(1, 11'h022, 3'b001, 32'hAAAABEEF, 0, rd);
        step(0, 11'h022, 3'b001, 32'h0, 0, rd);
        chk("lh", rd, 32'hFFFFBEEF);
        step(0, 11'h022, 3'b101, 32'h0, 0, rd);
        chk("lhu", rd, 32'h0000BEEF);
        step(0, 11'h020, 3'b010, 32'h0, 0, rd);
        chk("sh_word", rd, 32'hBEEF2468);
        step(0, 11'h021, 3'b001, 32'h0, 0, rd);
        chk("lh_misalign", rd, 32'h0);

        // Misaligned stores, first-error-wins, clear racing a new error.
        cnt_save = cnt_m;
        step(1, 11'h031, 3'b010, 32'h55555555, 0, rd);
        chk("mis_err", 32'(err), 32'd1);
        chk("mis_addr", 32'(eaddr), 32'h031);
        chk("mis_cnt", 32'(cnt), 32'(cnt_save));
        step(1, 11'h041, 3'b001, 32'h66666666, 0, rd);
        chk("first_wins", 32'(eaddr), 32'h031);
        step(1, 11'h035, 3'b010, 32'h77777777, 1, rd);
        chk("clr_set_err", 32'(err), 32'd1);
        chk("clr_set_addr", 32'(eaddr), 32'h035);
        step(0, 11'h030, 3'b010, 32'h0, 1, rd);
        chk("clr_err", 32'(err), 32'd0);
        step(1, 11'h040, 3'b011, 32'h0, 0, rd);
        chk("illegal_f3", 32'(eaddr), 32'h040);
        step(0, 11'h030, 3'b010, 32'h0, 1, rd);

        // Same-cycle read during write, then reset retention.
        step(1, 11'h050, 3'b010, 32'h22222222, 0, rd);
        step(1, 11'h050, 3'b010, 32'h11111111, 0, rd);
        chk("rdw_old", rd, 32'h22222222);
        step(0, 11'h050, 3'b010, 32'h0, 0, rd);
        chk("rdw_new", rd, 32'h11111111);
        pulse_reset();
        step(0, 11'h050, 3'b010, 32'h0, 0, rd);
        chk("rst_keep", rd, 32'h11111111);
        chk("rst_cnt", 32'(cnt), 32'd0);

        // Top word: MMIO register when enabled, otherwise plain RAM.
        step(1, 11'h7FC, 3'b010, 32'hCAFEF00D, 0, rd);
        step(0, 11'h7FC, 3'b010, 32'h0, 0, rd);
        chk("top_lw", rd, 32'hCAFEF00D);
`ifdef DMEM_MMIO_EN
        chk("mmio_val", mmio, 32'hCAFEF00D);
`endif
        step(1, 11'h7FE, 3'b001, 32'h0000ABCD, 0, rd);
        step(0, 11'h7FE, 3'b101, 32'h0, 0, rd);
        chk("top_lhu", rd, 32'h0000ABCD);

        // Randomized traffic, concentrated on a few words for collisions.
        for (int i = 0; i < 600; i++) begin
            logic [10:0] ra;
            bit          rw;
            bit          rc;
            ra = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(2040, 2047))
                                             : 11'($urandom_range(0, 63));
            rw = ($urandom_range(0, 1) == 1);
            rc = ($urandom_range(0, 7) == 0);
            step(rw, ra, 3'($urandom_range(0, 7)), $urandom, rc, rd);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
